// File: rtl/id_stage_ctrl.sv
// IF/ID pipeline register with load-use hazard detection, branch flush,
// opcode-class decode and saturating stall/flush event counters.
module id_stage_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [31:0]      if_pc,
  output logic             if_ready,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             id_valid,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc,
  output logic [2:0]       id_opclass,
  output logic [4:0]       id_rs1,
  output logic [4:0]       id_rs2,
  output logic             id_bubble,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    OC_OTHER  = 3'd0,
    OC_LOAD   = 3'd1,
    OC_OPIMM  = 3'd2,
    OC_STORE  = 3'd3,
    OC_BRANCH = 3'd4,
    OC_JAL    = 3'd5,
    OC_OP     = 3'd6
  } opclass_t;

  opclass_t opclass;
  logic     rs1_used;
  logic     rs2_used;
  logic     rd_match;

  always_comb begin
    opclass = OC_OTHER;
    unique case (id_instr[6:0])
      7'b0000011: opclass = OC_LOAD;
      7'b0010011: opclass = OC_OPIMM;
      7'b0100011: opclass = OC_STORE;
      7'b1100011: opclass = OC_BRANCH;
      7'b1101111: opclass = OC_JAL;
      7'b0110011: opclass = OC_OP;
      default:    opclass = OC_OTHER;
    endcase
  end

  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (opclass)
      OC_LOAD, OC_OPIMM:      rs1_used = 1'b1;
      OC_STORE, OC_BRANCH,
      OC_OP: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      default: begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
      end
    endcase
  end

  assign id_opclass = opclass;
  assign id_rs1     = id_instr[19:15];
  assign id_rs2     = id_instr[24:20];

  // A redirect kills the dependent instruction anyway, so it masks the hazard.
  always_comb begin
    rd_match  = (rs1_used && (ex_rd == id_rs1)) || (rs2_used && (ex_rd == id_rs2));
    stall     = id_valid && ex_mem_read && (ex_rd != '0) && rd_match && !ex_branch_taken;
    if_ready  = !stall;
    pc_write  = !stall;
    id_bubble = !id_valid || stall || ex_branch_taken;
  end

  // The PC is held on a flush; only the valid bit and the instruction word matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_instr <= NOP;
      id_pc    <= '0;
    end else if (ex_branch_taken) begin
      id_valid <= 1'b0;
      id_instr <= NOP;
    end else if (stall) begin
      id_valid <= id_valid;
    end else if (if_valid) begin
      id_valid <= 1'b1;
      id_instr <= if_instr;
      id_pc    <= if_pc;
    end else begin
      id_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (ex_branch_taken && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Self-checking bench for id_stage_ctrl: directed vector table, hand-written
// reset/saturation sequences and a randomized run against a reference model.
module tb_id_stage_ctrl;

  localparam int unsigned CW = 16;

  logic          clk;
  logic          rst;
  logic          if_valid;
  logic [31:0]   if_instr;
  logic [31:0]   if_pc;
  logic          if_ready;
  logic          ex_mem_read;
  logic [4:0]    ex_rd;
  logic          ex_branch_taken;
  logic          pc_write;
  logic          id_valid;
  logic [31:0]   id_instr;
  logic [31:0]   id_pc;
  logic [2:0]    id_opclass;
  logic [4:0]    id_rs1;
  logic [4:0]    id_rs2;
  logic          id_bubble;
  logic          stall;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  id_stage_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .pc_write(pc_write), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc(id_pc), .id_opclass(id_opclass), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_bubble(id_bubble), .stall(stall), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic mr, input logic [4:0] rd, input logic br);
    rst = r; if_valid = v; if_instr = ins; if_pc = pc;
    ex_mem_read = mr; ex_rd = rd; ex_branch_taken = br;
  endtask

  // Directed vectors: pre-edge comb results and post-edge register results.
  typedef struct {
    logic        r, v;
    logic [31:0] ins, pc;
    logic        mr;
    logic [4:0]  rd;
    logic        br;
    logic        e_stall, e_bubble;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [2:0]  e_cls;
    logic [4:0]  e_rs1;
    logic [15:0] e_scnt, e_fcnt;
  } vec_t;

  vec_t tbl[17];

  // Reference model: opcode table index gives the class, per-class source-use tables.
  bit [6:0] opc_tab [7] = '{7'h7f, 7'h03, 7'h13, 7'h23, 7'h63, 7'h6f, 7'h33};
  bit       use1_tab[7] = '{0, 1, 1, 1, 1, 0, 1};
  bit       use2_tab[7] = '{0, 0, 0, 1, 1, 0, 1};

  function automatic int cls_of(input logic [31:0] ins);
    cls_of = 0;
    for (int k = 1; k < 7; k++)
      if (ins[6:0] == opc_tab[k]) cls_of = k;
  endfunction

  logic          m_valid;
  logic [31:0]   m_instr, m_pc;
  int unsigned   m_scnt, m_fcnt;

  function automatic bit m_hazard();
    int c;
    int s1, s2;
    c  = cls_of(m_instr);
    s1 = int'(m_instr[19:15]);
    s2 = int'(m_instr[24:20]);
    if (!m_valid || !ex_mem_read || ex_branch_taken || ex_rd == 5'd0) return 1'b0;
    return (use1_tab[c] && int'(ex_rd) == s1) || (use2_tab[c] && int'(ex_rd) == s2);
  endfunction

  task automatic model_edge();
    bit h;
    h = m_hazard();
    if (rst) begin
      m_valid = 0; m_instr = 32'h13; m_pc = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (h && m_scnt < 65535) m_scnt++;
      if (ex_branch_taken && m_fcnt < 65535) m_fcnt++;
      if (ex_branch_taken) begin
        m_valid = 0; m_instr = 32'h13;
      end else if (!h) begin
        m_valid = if_valid;
        if (if_valid) begin m_instr = if_instr; m_pc = if_pc; end
      end
    end
  endtask

  task automatic check_model();
    bit h;
    h = m_hazard();
    chk("rnd id_valid", {31'd0, id_valid}, {31'd0, m_valid});
    chk("rnd id_instr", id_instr, m_instr);
    chk("rnd id_pc", id_pc, m_pc);
    chk("rnd id_opclass", {29'd0, id_opclass}, cls_of(m_instr));
    chk("rnd id_rs1", {27'd0, id_rs1}, {27'd0, m_instr[19:15]});
    chk("rnd id_rs2", {27'd0, id_rs2}, {27'd0, m_instr[24:20]});
    chk("rnd stall", {31'd0, stall}, {31'd0, h});
    chk("rnd if_ready", {31'd0, if_ready}, {31'd0, !h});
    chk("rnd pc_write", {31'd0, pc_write}, {31'd0, !h});
    chk("rnd id_bubble", {31'd0, id_bubble}, {31'd0, (!m_valid || h || ex_branch_taken)});
    chk("rnd stall_cnt", {16'd0, stall_cnt}, m_scnt);
    chk("rnd flush_cnt", {16'd0, flush_cnt}, m_fcnt);
  endtask

  initial begin
    //            r  v  ins           pc      mr rd br  st bb  val instr        cls rs1 scnt fcnt
    tbl[0]  = '{0, 1, 32'h00500093, 32'h100, 0, 0, 0,  0, 1,  1, 32'h00500093, 2, 0, 0, 0};
    tbl[1]  = '{0, 1, 32'h002081B3, 32'h104, 1, 1, 0,  0, 0,  1, 32'h002081B3, 6, 1, 0, 0};
    tbl[2]  = '{0, 1, 32'h00000013, 32'h108, 1, 2, 0,  1, 1,  1, 32'h002081B3, 6, 1, 1, 0};
    tbl[3]  = '{0, 1, 32'h00000013, 32'h108, 0, 2, 0,  0, 0,  1, 32'h00000013, 2, 0, 1, 0};
    tbl[4]  = '{0, 1, 32'h002081B3, 32'h10C, 0, 0, 0,  0, 0,  1, 32'h002081B3, 6, 1, 1, 0};
    tbl[5]  = '{0, 0, 32'hDEADBEEF, 32'h999, 1, 0, 0,  0, 0,  0, 32'h002081B3, 6, 1, 1, 0};
    tbl[6]  = '{0, 1, 32'h008000EF, 32'h110, 0, 0, 0,  0, 1,  1, 32'h008000EF, 5, 0, 1, 0};
    tbl[7]  = '{0, 0, 32'h00000000, 32'h000, 1, 8, 0,  0, 0,  0, 32'h008000EF, 5, 0, 1, 0};
    tbl[8]  = '{0, 1, 32'h002081B3, 32'h114, 0, 0, 0,  0, 1,  1, 32'h002081B3, 6, 1, 1, 0};
    tbl[9]  = '{0, 1, 32'h00500093, 32'h118, 1, 1, 1,  0, 1,  0, 32'h00000013, 2, 0, 1, 1};
    tbl[10] = '{0, 1, 32'h00300113, 32'h200, 0, 0, 0,  0, 1,  1, 32'h00300113, 2, 0, 1, 1};
    tbl[11] = '{0, 1, 32'h002081B3, 32'h204, 1, 2, 0,  0, 0,  1, 32'h002081B3, 6, 1, 1, 1};
    tbl[12] = '{0, 1, 32'h0000A183, 32'h208, 1, 1, 0,  1, 1,  1, 32'h002081B3, 6, 1, 2, 1};
    tbl[13] = '{0, 1, 32'h0000A183, 32'h208, 1, 1, 0,  1, 1,  1, 32'h002081B3, 6, 1, 3, 1};
    tbl[14] = '{0, 1, 32'h0000A183, 32'h208, 0, 1, 0,  0, 0,  1, 32'h0000A183, 1, 1, 3, 1};
    tbl[15] = '{0, 0, 32'h00000000, 32'h000, 1, 1, 0,  1, 1,  1, 32'h0000A183, 1, 1, 4, 1};
    tbl[16] = '{1, 1, 32'h002081B3, 32'h300, 1, 1, 0,  1, 1,  0, 32'h00000013, 2, 0, 0, 0};

    drive(1, 0, 32'h0, 32'h0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset id_valid", {31'd0, id_valid}, 32'd0);
    chk("reset id_instr", id_instr, 32'h13);
    chk("reset id_pc", id_pc, 32'd0);
    chk("reset counters", {stall_cnt, flush_cnt}, 32'd0);
    chk("reset if_ready", {31'd0, if_ready}, 32'd1);
    chk("reset pc_write", {31'd0, pc_write}, 32'd1);
    chk("reset id_bubble", {31'd0, id_bubble}, 32'd1);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].ins, tbl[i].pc, tbl[i].mr, tbl[i].rd, tbl[i].br);
      #1;
      chk($sformatf("vec%0d stall", i), {31'd0, stall}, {31'd0, tbl[i].e_stall});
      chk($sformatf("vec%0d id_bubble", i), {31'd0, id_bubble}, {31'd0, tbl[i].e_bubble});
      chk($sformatf("vec%0d if_ready", i), {31'd0, if_ready}, {31'd0, !tbl[i].e_stall});
      chk($sformatf("vec%0d pc_write", i), {31'd0, pc_write}, {31'd0, !tbl[i].e_stall});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d id_valid", i), {31'd0, id_valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("vec%0d id_instr", i), id_instr, tbl[i].e_instr);
      chk($sformatf("vec%0d id_opclass", i), {29'd0, id_opclass}, {29'd0, tbl[i].e_cls});
      chk($sformatf("vec%0d id_rs1", i), {27'd0, id_rs1}, {27'd0, tbl[i].e_rs1});
      chk($sformatf("vec%0d stall_cnt", i), {16'd0, stall_cnt}, {16'd0, tbl[i].e_scnt});
      chk($sformatf("vec%0d flush_cnt", i), {16'd0, flush_cnt}, {16'd0, tbl[i].e_fcnt});
      @(negedge clk);
    end
    // Reset taken during a stall: hazard inputs still applied, yet fetch is open again.
    chk("post-reset if_ready", {31'd0, if_ready}, 32'd1);
    chk("post-reset stall", {31'd0, stall}, 32'd0);
    chk("post-reset id_pc", id_pc, 32'd0);

    drive(1, 0, 32'h0, 32'h0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    m_valid = 0; m_instr = 32'h13; m_pc = 0; m_scnt = 0; m_fcnt = 0;
    for (int n = 0; n < 3000; n++) begin
      logic [6:0]  opc;
      logic [31:0] ins;
      case ($urandom_range(0, 7))
        0: opc = 7'h03; 1: opc = 7'h13; 2: opc = 7'h23; 3: opc = 7'h63;
        4: opc = 7'h6f; 5: opc = 7'h33; 6: opc = 7'h37; default: opc = 7'h7f;
      endcase
      ins = $urandom;
      ins[6:0]   = opc;
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, ins, $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
      #1;
      check_model();
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end

    // Saturation: a hazard held for longer than the counter range.
    drive(1, 0, 32'h0, 32'h0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1, 32'h002081B3, 32'h400, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1, 32'h00000013, 32'h404, 1, 2, 0);
    repeat (65535) @(posedge clk);
    @(negedge clk);
    chk("sat stall_cnt reaches max", {16'd0, stall_cnt}, 32'h0000FFFF);
    chk("sat stall still active", {31'd0, stall}, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sat stall_cnt holds max", {16'd0, stall_cnt}, 32'h0000FFFF);
    chk("sat id_instr held", id_instr, 32'h002081B3);
    chk("sat flush_cnt", {16'd0, flush_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
